// File: rtl/cart_dl_buffer.sv
// ============================================================================
// cart_dl_buffer: FIFO-buffered cartridge download front end with header capture
// Revision: 1.0
// ============================================================================
`default_nettype none

module cart_dl_buffer #(
  parameter int DW       = 16,
  parameter int AW       = 25,
  parameter int DEPTH    = 8,
  parameter int HI_WATER = 6
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ce_cpu,
  input  logic          ce_cpu2x,
  input  logic          speed,
  input  logic          cart_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_dout,
  output logic          ioctl_wait,
  output logic          dn_write,
  output logic [AW-1:0] dn_addr,
  output logic [DW-1:0] dn_data,
  output logic          cart_ready,
  output logic          overflow,
  output logic [7:0]    cart_mbc_type,
  output logic [7:0]    cart_sgb_flag,
  output logic [7:0]    cart_rom_size,
  output logic [7:0]    cart_ram_size,
  output logic [7:0]    cart_old_licensee,
  output logic          cart_cgb_flag,
  output logic [8:0]    rom_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_READY = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           dl_q, dl_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           dn_write_q, dn_write_d;
  logic [AW-1:0]  dn_addr_q, dn_addr_d;
  logic [DW-1:0]  dn_data_q, dn_data_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     mbc_q, mbc_d;
  logic [7:0]     sgb_q, sgb_d;
  logic [7:0]     rom_size_q, rom_size_d;
  logic [7:0]     ram_size_q, ram_size_d;
  logic [7:0]     old_lic_q, old_lic_d;
  logic           cgb_q, cgb_d;
  logic [8:0]     rom_mask_q, rom_mask_d;

  logic [AW-1:0]  fifo_addr_mem [DEPTH];
  logic [DW-1:0]  fifo_data_mem [DEPTH];

  logic           drain_tick, dl_rise, dl_fall;
  logic           push_req, push_ok, pop, full;
  logic           hdr_hit;
  logic [PW-1:0]  wr_base;
  logic [8:0]     mask_base;

  always_comb begin
    drain_tick = speed ? ce_cpu2x : ce_cpu;
    dl_rise    = cart_download & ~dl_q;
    dl_fall    = ~cart_download & dl_q;
    push_req   = ioctl_wr & cart_download;
    full       = (count_q == CW'(DEPTH));
    // A download rise flushes the queue, so nothing is popped that cycle
    pop        = drain_tick & (count_q != '0) & ~dl_rise;
    push_ok    = push_req & (dl_rise | ~full | pop);
    hdr_hit    = push_ok & (ioctl_addr[AW-1:12] == '0);
    wr_base    = dl_rise ? '0 : wr_ptr_q;
    mask_base  = dl_rise ? 9'd0 : rom_mask_q;

    dl_d       = cart_download;
    rd_ptr_d   = (dl_rise ? '0 : rd_ptr_q) + PW'(pop);
    wr_ptr_d   = wr_base + PW'(push_ok);
    count_d    = (dl_rise ? '0 : count_q) + CW'(push_ok) - CW'(pop);

    dn_write_d = pop;
    dn_addr_d  = pop ? fifo_addr_mem[rd_ptr_q] : dn_addr_q;
    dn_data_d  = pop ? fifo_data_mem[rd_ptr_q] : dn_data_q;

    overflow_d = (dl_rise ? 1'b0 : overflow_q) | (push_req & ~push_ok);

    mbc_d      = dl_rise ? 8'd0 : mbc_q;
    sgb_d      = dl_rise ? 8'd0 : sgb_q;
    rom_size_d = dl_rise ? 8'd0 : rom_size_q;
    ram_size_d = dl_rise ? 8'd0 : ram_size_q;
    old_lic_d  = dl_rise ? 8'd0 : old_lic_q;
    cgb_d      = dl_rise ? 1'b0 : cgb_q;
    if (hdr_hit) begin
      case (ioctl_addr[11:0])
        12'h142: cgb_d = ioctl_dout[15];
        12'h146: {mbc_d, sgb_d} = ioctl_dout[15:0];
        12'h148: {ram_size_d, rom_size_d} = ioctl_dout[15:0];
        12'h14A: old_lic_d = ioctl_dout[15:8];
        default: ;
      endcase
    end

    rom_mask_d = mask_base;
    if (push_ok && (ioctl_addr[22:14] > mask_base)) begin
      rom_mask_d = ioctl_addr[22:14];
    end

    state_d = state_q;
    if (dl_rise) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  if (dl_fall) state_d = ST_FLUSH;
        ST_FLUSH: if (count_q == '0) state_d = ST_READY;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dl_q       <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      dn_write_q <= 1'b0;
      dn_addr_q  <= '0;
      dn_data_q  <= '0;
      overflow_q <= 1'b0;
      mbc_q      <= 8'd0;
      sgb_q      <= 8'd0;
      rom_size_q <= 8'd0;
      ram_size_q <= 8'd0;
      old_lic_q  <= 8'd0;
      cgb_q      <= 1'b0;
      rom_mask_q <= 9'd0;
    end else begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      dn_write_q <= dn_write_d;
      dn_addr_q  <= dn_addr_d;
      dn_data_q  <= dn_data_d;
      overflow_q <= overflow_d;
      mbc_q      <= mbc_d;
      sgb_q      <= sgb_d;
      rom_size_q <= rom_size_d;
      ram_size_q <= ram_size_d;
      old_lic_q  <= old_lic_d;
      cgb_q      <= cgb_d;
      rom_mask_q <= rom_mask_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live
  always_ff @(posedge clk_sys) begin
    if (reset_n && push_ok) begin
      fifo_addr_mem[wr_base] <= ioctl_addr;
      fifo_data_mem[wr_base] <= ioctl_dout;
    end
  end

  assign ioctl_wait        = (count_q >= CW'(HI_WATER)) | (state_q == ST_FLUSH);
  assign dn_write          = dn_write_q;
  assign dn_addr           = dn_addr_q;
  assign dn_data           = dn_data_q;
  assign cart_ready        = (state_q == ST_READY);
  assign overflow          = overflow_q;
  assign cart_mbc_type     = mbc_q;
  assign cart_sgb_flag     = sgb_q;
  assign cart_rom_size     = rom_size_q;
  assign cart_ram_size     = ram_size_q;
  assign cart_old_licensee = old_lic_q;
  assign cart_cgb_flag     = cgb_q;
  assign rom_mask          = rom_mask_q;

endmodule

`default_nettype wire

// File: tb/tb_cart_dl_buffer.sv
// ============================================================================
// tb_cart_dl_buffer: directed table-driven bench for cart_dl_buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cart_dl_buffer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce_cpu, ce_cpu2x, speed;
  logic        cart_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait, dn_write, cart_ready, overflow, cart_cgb_flag;
  logic [24:0] dn_addr;
  logic [15:0] dn_data;
  logic [7:0]  cart_mbc_type, cart_sgb_flag, cart_rom_size, cart_ram_size, cart_old_licensee;
  logic [8:0]  rom_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  cart_dl_buffer #(.DW(16), .AW(25), .DEPTH(8), .HI_WATER(6)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .ce_cpu2x(ce_cpu2x),
    .speed(speed), .cart_download(cart_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .dn_write(dn_write), .dn_addr(dn_addr), .dn_data(dn_data),
    .cart_ready(cart_ready), .overflow(overflow), .cart_mbc_type(cart_mbc_type),
    .cart_sgb_flag(cart_sgb_flag), .cart_rom_size(cart_rom_size),
    .cart_ram_size(cart_ram_size), .cart_old_licensee(cart_old_licensee),
    .cart_cgb_flag(cart_cgb_flag), .rom_mask(rom_mask)
  );

  typedef struct packed {
    logic        dl;
    logic        wr;
    logic [24:0] addr;
    logic [15:0] dout;
    logic        tick;
    logic        e_dnw;
    logic [24:0] e_addr;
    logic        e_wait;
    logic        e_ready;
    logic        e_ovf;
    logic [7:0]  e_mbc;
    logic [7:0]  e_rom;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (normal-speed drain) and sample just after the edge
  task automatic cyc(input logic dl, input logic wr, input logic [24:0] addr,
                     input logic [15:0] dout, input logic tick);
    cart_download = dl;
    ioctl_wr      = wr;
    ioctl_addr    = addr;
    ioctl_dout    = dout;
    ce_cpu        = tick;
    ce_cpu2x      = 1'b0;
    speed         = 1'b0;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dnw"},  {31'd0, dn_write}, 0);
    chk({tag, "_addr"}, {7'd0, dn_addr}, 0);
    chk({tag, "_data"}, {16'd0, dn_data}, 0);
    chk({tag, "_wait"}, {31'd0, ioctl_wait}, 0);
    chk({tag, "_rdy"},  {31'd0, cart_ready}, 0);
    chk({tag, "_ovf"},  {31'd0, overflow}, 0);
    chk({tag, "_hdr"},  {cart_mbc_type, cart_sgb_flag, cart_rom_size, cart_ram_size}, 0);
    chk({tag, "_hdr2"}, {23'd0, cart_old_licensee, cart_cgb_flag}, 0);
    chk({tag, "_mask"}, {23'd0, rom_mask}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [24:0] a4 [33];
    logic [24:0] qa [$];
    logic [24:0] ea;
    logic        exp_pop;
    int          idx, occ;
    vec_t        v;

    // dl wr addr dout tick | dnw e_addr wait ready ovf mbc rom
    tbl[0]  = {1'b1, 1'b1, 25'h146,   16'h1303, 1'b0, 1'b0, 25'h0,   1'b0, 1'b0, 1'b0, 8'h13, 8'h00};
    tbl[1]  = {1'b1, 1'b1, 25'h148,   16'h0205, 1'b1, 1'b1, 25'h146, 1'b0, 1'b0, 1'b0, 8'h13, 8'h05};
    tbl[2]  = {1'b1, 1'b0, 25'h0,     16'h0000, 1'b1, 1'b1, 25'h148, 1'b0, 1'b0, 1'b0, 8'h13, 8'h05};
    tbl[3]  = {1'b0, 1'b0, 25'h0,     16'h0000, 1'b0, 1'b0, 25'h0,   1'b1, 1'b0, 1'b0, 8'h13, 8'h05};
    tbl[4]  = {1'b0, 1'b0, 25'h0,     16'h0000, 1'b0, 1'b0, 25'h0,   1'b0, 1'b1, 1'b0, 8'h13, 8'h05};
    tbl[5]  = {1'b0, 1'b1, 25'h146,   16'hFFFF, 1'b1, 1'b0, 25'h0,   1'b0, 1'b1, 1'b0, 8'h13, 8'h05};
    tbl[6]  = {1'b1, 1'b1, 25'h100,   16'hAAAA, 1'b0, 1'b0, 25'h0,   1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[7]  = {1'b1, 1'b1, 25'h102,   16'h5555, 1'b0, 1'b0, 25'h0,   1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[8]  = {1'b0, 1'b0, 25'h0,     16'h0000, 1'b0, 1'b0, 25'h0,   1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[9]  = {1'b0, 1'b0, 25'h0,     16'h0000, 1'b1, 1'b1, 25'h100, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[10] = {1'b0, 1'b0, 25'h0,     16'h0000, 1'b1, 1'b1, 25'h102, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[11] = {1'b0, 1'b0, 25'h0,     16'h0000, 1'b0, 1'b0, 25'h0,   1'b0, 1'b1, 1'b0, 8'h00, 8'h00};

    reset_n = 1'b0;
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Header capture, flush/ready sequencing, writes outside the window
    for (int i = 0; i < 12; i++) begin
      v = tbl[i];
      cyc(v.dl, v.wr, v.addr, v.dout, v.tick);
      chk($sformatf("tbl%0d_dnw", i), {31'd0, dn_write}, {31'd0, v.e_dnw});
      if (v.e_dnw) chk($sformatf("tbl%0d_addr", i), {7'd0, dn_addr}, {7'd0, v.e_addr});
      chk($sformatf("tbl%0d_wait", i), {31'd0, ioctl_wait}, {31'd0, v.e_wait});
      chk($sformatf("tbl%0d_rdy", i), {31'd0, cart_ready}, {31'd0, v.e_ready});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, overflow}, {31'd0, v.e_ovf});
      chk($sformatf("tbl%0d_mbc", i), {24'd0, cart_mbc_type}, {24'd0, v.e_mbc});
      chk($sformatf("tbl%0d_rom", i), {24'd0, cart_rom_size}, {24'd0, v.e_rom});
      if (i == 1) begin
        chk("tbl1_sgb", {24'd0, cart_sgb_flag}, 32'h03);
        chk("tbl1_ram", {24'd0, cart_ram_size}, 32'h02);
      end
    end

    // Reset in the middle of a load with five entries queued
    cyc(1'b1, 1'b1, 25'h146,  16'h1303, 1'b0);
    cyc(1'b1, 1'b1, 25'h4000, 16'h0001, 1'b0);
    cyc(1'b1, 1'b1, 25'h8000, 16'h0002, 1'b0);
    cyc(1'b1, 1'b1, 25'hC000, 16'h0003, 1'b0);
    cyc(1'b1, 1'b1, 25'h14A,  16'h3300, 1'b0);
    chk("t1_wait5", {31'd0, ioctl_wait}, 0);
    chk("t1_mask",  {23'd0, rom_mask}, 32'h3);
    chk("t1_lic",   {24'd0, cart_old_licensee}, 32'h33);
    reset_n = 1'b0;
    cyc(1'b1, 1'b0, 25'h0, 16'h0, 1'b1);
    chk_all_zero("t1_rst");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 25'h0, 16'h0, 1'b1);
      chk($sformatf("t1_nodn%0d", i), {31'd0, dn_write}, 0);
    end

    // Burst to full with no drain, watermark and dropped ninth push
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b1, 25'h200 + 25'(2 * k), 16'(k), 1'b0);
      chk($sformatf("t3_wait%0d", k), {31'd0, ioctl_wait}, {31'd0, (k >= 6)});
      chk($sformatf("t3_ovf%0d", k), {31'd0, overflow}, 0);
    end
    cyc(1'b1, 1'b1, 25'h300, 16'hDEAD, 1'b0);
    chk("t3_ovf_set", {31'd0, overflow}, 1);
    cyc(1'b1, 1'b0, 25'h0, 16'h0, 1'b0);
    chk("t3_ovf_sticky", {31'd0, overflow}, 1);
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    chk("t3_flush_wait", {31'd0, ioctl_wait}, 1);
    cyc(1'b1, 1'b0, 25'h0, 16'h0, 1'b0);
    chk("t3_ovf_clr", {31'd0, overflow}, 0);
    chk("t3_wait_clr", {31'd0, ioctl_wait}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 25'h0, 16'h0, 1'b1);
      chk($sformatf("t3_empty%0d", i), {31'd0, dn_write}, 0);
    end

    // Full FIFO with simultaneous push and pop
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 25'h1000 + 25'(2 * k), 16'hA000 + 16'(k), 1'b0);
    chk("t5_full_wait", {31'd0, ioctl_wait}, 1);
    cyc(1'b1, 1'b1, 25'h2000, 16'hBEEF, 1'b1);
    chk("t5_dnw",  {31'd0, dn_write}, 1);
    chk("t5_addr", {7'd0, dn_addr}, 32'h1000);
    chk("t5_data", {16'd0, dn_data}, 32'hA000);
    chk("t5_ovf",  {31'd0, overflow}, 0);
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 1'b0, 25'h0, 16'h0, 1'b1);
      chk($sformatf("t5_dnw%0d", j), {31'd0, dn_write}, 1);
      chk($sformatf("t5_addr%0d", j), {7'd0, dn_addr},
          (j < 7) ? 32'h1002 + 32'(2 * j) : 32'h2000);
      chk($sformatf("t5_data%0d", j), {16'd0, dn_data},
          (j < 7) ? 32'hA001 + 32'(j) : 32'hBEEF);
    end
    cyc(1'b1, 1'b0, 25'h0, 16'h0, 1'b1);
    chk("t5_drained", {31'd0, dn_write}, 0);
    chk("t5_wait0",   {31'd0, ioctl_wait}, 0);

    // Double-speed drain with host honouring ioctl_wait
    for (int k = 0; k < 32; k++) a4[k] = 25'(k * 32'h4000);
    a4[32] = 25'h07FFFE;
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 25'h0, 16'h0, 1'b0);
    idx = 0;
    occ = 0;
    for (int i = 0; i < 400 && !(idx == 33 && occ == 0); i++) begin
      speed         = 1'b1;
      ce_cpu2x      = (i % 2 == 0);
      ce_cpu        = ~ce_cpu2x;
      cart_download = 1'b1;
      ioctl_wr      = !ioctl_wait && (idx < 33);
      ioctl_addr    = (idx < 33) ? a4[idx] : 25'h0;
      ioctl_dout    = ioctl_addr[16:1];
      exp_pop       = ce_cpu2x && (occ > 0);
      ea            = '0;
      if (exp_pop) ea = qa.pop_front();
      if (ioctl_wr) begin
        qa.push_back(a4[idx]);
        idx++;
      end
      occ = occ + (ioctl_wr ? 1 : 0) - (exp_pop ? 1 : 0);
      @(posedge clk_sys);
      #1;
      chk($sformatf("t4_dnw_c%0d", i), {31'd0, dn_write}, {31'd0, exp_pop});
      if (exp_pop) begin
        chk($sformatf("t4_addr_c%0d", i), {7'd0, dn_addr}, {7'd0, ea});
        chk($sformatf("t4_data_c%0d", i), {16'd0, dn_data}, {16'd0, ea[16:1]});
      end
    end
    chk("t4_done", {31'd0, (idx == 33 && occ == 0)}, 1);
    chk("t4_mask", {23'd0, rom_mask}, 32'h01F);
    chk("t4_ovf",  {31'd0, overflow}, 0);
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    chk("t4_flush", {31'd0, cart_ready}, 0);
    cyc(1'b0, 1'b0, 25'h0, 16'h0, 1'b0);
    chk("t4_ready", {31'd0, cart_ready}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
